mips_issue_queue: RTL and testbench
===================================

# mips_issue_queue

- Parametrised in-order instruction queue between fetch and decode of the superscalar MIPS core.
- Replaces the fixed two-slot IF/ID handoff: accepts up to FETCH_W instructions per cycle, stores them in a DEPTH-entry circular buffer, and presents the ISSUE_W oldest entries with their PCs to decode/pairing logic.
- Decode reports how many it consumed each cycle; branch or jump redirects flush the queue.

## Interface
Parameters:
- FETCH_W, 2: instructions per fetch bundle, ≥1.
- ISSUE_W, 2: issue slots presented to decode, ≥1.
- DEPTH, 8: queue entries; power of 2, ≥ FETCH_W+ISSUE_W.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- fetch_valid  in  1  bundle present.
- fetch_inst  in  32*FETCH_W  slot k in bits [32k+31:32k]; slot 0 oldest.
- fetch_pc  in  32  PC of slot 0; slot k PC = fetch_pc+4k, computed modulo 2^32.
- fetch_cnt  in  clog2(FETCH_W+1)  valid slots, 1..FETCH_W, always starting at slot 0.
- fetch_ready  out  1  free entries ≥ FETCH_W.
- issue_valid  out  ISSUE_W  bit k = entry k present; always a contiguous thermometer from bit 0.
- issue_inst  out  32*ISSUE_W  oldest-first; 32'h0 (NOP) in invalid slots.
- issue_pc  out  32*ISSUE_W  PCs matching issue_inst; 0 in invalid slots.
- issue_take  in  clog2(ISSUE_W+1)  entries consumed this cycle, counted from slot 0.
- flush  in  1  discard all contents.
- occupancy  out  clog2(DEPTH+1)  valid entries held.

## Operation
- State:
  - head and tail pointers, each clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - count register.
  - storage of DEPTH × {inst, pc}.
- Accept rule: fetch_valid & fetch_ready & !flush.
  - Writes fetch_cnt entries at tail..tail+fetch_cnt-1, wrapping modulo DEPTH.
  - tail advances by fetch_cnt.
  - fetch_valid while !fetch_ready: bundle ignored; fetch must hold it.
- fetch_ready is computed from the registered count only (DEPTH-count ≥ FETCH_W). A same-cycle pop does not raise it.
- Pop rule: head advances by min(issue_take, available).
  - An issue_take above available is clamped.
  - In simulation the clamp also fires an assertion.
- Push and pop in the same cycle: count_next = count + pushed - popped. Both are legal at any occupancy, including wrap-around of either pointer.
- Flush:
  - Next cycle: head=tail=0, count=0.
  - Same-cycle fetch and issue_take are ignored.
  - Flush has priority over everything except rst.
- Reset, in the cycle after rst is sampled high:
  - head=tail=count=0.
  - issue_valid=0, issue_inst=0, issue_pc=0.
  - occupancy=0, fetch_ready=1.
- rst asserted mid-stream drops all entries, same as flush.

## Timing
- Without bypass, an accepted entry appears on issue outputs on the cycle after acceptance (latency 1).
- Issue outputs are combinational reads of registered storage at head..head+ISSUE_W-1. They do not depend on issue_take in the same cycle.
- Steady state with FETCH_W=ISSUE_W and full take: one bundle in and one out per cycle. Occupancy stays constant.
- Full (count=DEPTH): fetch_ready=0.
- Empty: issue_valid=0.

## Configuration
- Macro: ISSUEQ_BYPASS_EN.
- Defined: when count=0 and a bundle is accepted, its slots drive issue outputs in the same cycle (latency 0).
  - Of those, min(issue_take, fetch_cnt) are popped directly and never written.
  - The remainder is stored at tail.
  - Flush still suppresses the bypass.
- Undefined: no combinational fetch-to-issue path; latency is exactly 1.

## Structure
- Shared package mips_ss_pkg holds:
  - INST_W=32 and PC_W=32.
  - NOP_INST=32'h0.
  - The clog2-based width helpers for pointer and count widths.
- One sub-module, issue_queue_store:
  - DEPTH-entry register array of {inst, pc}.
  - FETCH_W write ports, each with its own index and enable.
  - ISSUE_W combinational read ports, with modulo-DEPTH indexing internal to it.
  - Reset is not needed on storage, because validity comes from count.

## Test plan
1. Reset: rst high one cycle -> occupancy 0, issue_valid 2'b00, issue_inst 0, fetch_ready 1.
2. Push {A,B}@pc 0x0 then {C,D}@0x8 with take=0 -> occupancy 4; slot0 A/0x0, slot1 B/0x4. Then take=1 -> slot0 B/0x4, slot1 C/0x8.
3. Fill to 8 -> fetch_ready 0. Next cycle fetch_valid=1 and take=2 -> bundle rejected, occupancy 6, fetch_ready 1 the following cycle.
4. fetch_cnt=1 at pc 0x104 into an empty queue -> occupancy 1, issue_valid 2'b01, issue_pc slot0 0x104, slot1 inst/pc 0.
5. 20 bundles with take=2 every cycle, pointers wrapping twice -> order and PCs preserved (+4 each), no drops. Then take=2 at occupancy 1 -> clamped, occupancy 0, assertion fires.
6. flush with fetch_valid=1 and take=2 at occupancy 5 -> next cycle occupancy 0, issue_valid 0.
   - With ISSUEQ_BYPASS_EN: fetch {E,F} into an empty queue with take=2 -> E,F issued in the same cycle, occupancy stays 0.
   - Without ISSUEQ_BYPASS_EN: the same stimulus gives occupancy 2, and E,F are visible the next cycle.

Source files
------------

// File: rtl/mips_ss_pkg.sv
// Shared types, widths and helpers for the superscalar MIPS front end.
package mips_ss_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } iq_entry_t;

    // Storage index width; pointers carry one extra wrap bit.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/issue_queue_store.sv
// Register array for the issue queue: FETCH_W indexed write ports and
// ISSUE_W combinational read ports starting at rd_base, wrapping modulo DEPTH.
module issue_queue_store
    import mips_ss_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    localparam int IW     = idx_w(DEPTH)
) (
    input  logic                         clk,
    input  logic [FETCH_W-1:0]           wr_en,
    input  logic [FETCH_W-1:0][IW-1:0]   wr_idx,
    input  iq_entry_t [FETCH_W-1:0]      wr_data,
    input  logic [IW-1:0]                rd_base,
    output iq_entry_t [ISSUE_W-1:0]      rd_data
);

    iq_entry_t mem [DEPTH];

    // NOTE: storage has no reset; entry validity comes from the queue's count,
    // so stale contents are never observable.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (wr_en[k]) begin
                mem[wr_idx[k]] <= wr_data[k];
            end
        end
    end

    always_comb begin
        logic [IW-1:0] rd_idx;
        for (int k = 0; k < ISSUE_W; k++) begin
            rd_idx     = rd_base + IW'(k);
            rd_data[k] = mem[rd_idx];
        end
    end

endmodule

// File: rtl/mips_issue_queue.sv
// In-order fetch-to-decode instruction queue of the superscalar MIPS core.
// Define ISSUEQ_BYPASS_EN to let a bundle arriving at an empty queue issue in the same cycle.
module mips_issue_queue
    import mips_ss_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_valid,
    input  logic [INST_W*FETCH_W-1:0]    fetch_inst,
    input  logic [PC_W-1:0]              fetch_pc,
    input  logic [cnt_w(FETCH_W)-1:0]    fetch_cnt,
    output logic                         fetch_ready,
    output logic [ISSUE_W-1:0]           issue_valid,
    output logic [INST_W*ISSUE_W-1:0]    issue_inst,
    output logic [PC_W*ISSUE_W-1:0]      issue_pc,
    input  logic [cnt_w(ISSUE_W)-1:0]    issue_take,
    input  logic                         flush,
    output logic [cnt_w(DEPTH)-1:0]      occupancy
);

    localparam int PW = ptr_w(DEPTH);
    localparam int IW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int FW = cnt_w(FETCH_W);

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    logic          accept, bypass;
    logic [CW-1:0] fetch_n, push_cnt, take_req, avail, pop_cnt, direct_pop;

    iq_entry_t [FETCH_W-1:0]       wr_data;
    logic [FETCH_W-1:0]            wr_en;
    logic [FETCH_W-1:0][IW-1:0]    wr_idx;
    iq_entry_t [ISSUE_W-1:0]       rd_data;

    always_comb begin
        fetch_ready = (CW'(DEPTH) - count) >= CW'(FETCH_W);
        accept      = fetch_valid && fetch_ready && !flush && !rst;
        fetch_n     = (fetch_cnt > FW'(FETCH_W)) ? CW'(FETCH_W) : CW'(fetch_cnt);
        push_cnt    = accept ? fetch_n : '0;
        take_req    = CW'(issue_take);
`ifdef ISSUEQ_BYPASS_EN
        bypass      = accept && (count == '0);
`else
        bypass      = 1'b0;
`endif
        // While bypassing, the arriving bundle is what decode sees.
        avail       = bypass ? push_cnt : count;
        pop_cnt     = (take_req > avail) ? avail : take_req;
        direct_pop  = bypass ? pop_cnt : '0;
    end

    // Slots consumed directly by a bypass are skipped; tail still advances past them.
    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            wr_data[k].inst = fetch_inst[INST_W*k +: INST_W];
            wr_data[k].pc   = fetch_pc + PC_W'(4 * k);
            wr_idx[k]       = tail[IW-1:0] + IW'(k);
            wr_en[k]        = (CW'(k) < push_cnt) && (CW'(k) >= direct_pop);
        end
    end

    issue_queue_store #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W)
    ) u_store (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_base (head[IW-1:0]),
        .rd_data (rd_data)
    );

    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            issue_valid[k]               = 1'b0;
            issue_inst[INST_W*k +: INST_W] = NOP_INST;
            issue_pc[PC_W*k +: PC_W]     = '0;
            if (CW'(k) < count) begin
                issue_valid[k]               = 1'b1;
                issue_inst[INST_W*k +: INST_W] = rd_data[k].inst;
                issue_pc[PC_W*k +: PC_W]     = rd_data[k].pc;
            end
`ifdef ISSUEQ_BYPASS_EN
            else if (bypass && (CW'(k) < push_cnt)) begin
                issue_valid[k]               = 1'b1;
                issue_inst[INST_W*k +: INST_W] = wr_data[k].inst;
                issue_pc[PC_W*k +: PC_W]     = wr_data[k].pc;
            end
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_cnt);
            tail  <= tail + PW'(push_cnt);
            count <= count + push_cnt - pop_cnt;
        end
    end

    assign occupancy = count;

    // Decode asking for more than is presented is clamped above; flag it in simulation.
    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (take_req <= avail)
            else $warning("issue_take %0d clamped to %0d", take_req, avail);
        end
    end

endmodule

// File: tb/tb_mips_issue_queue.sv
// Self-checking bench for mips_issue_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_mips_issue_queue;

    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [63:0] fetch_inst = '0;
    logic [31:0] fetch_pc = '0;
    logic [1:0]  fetch_cnt = '0;
    logic [1:0]  issue_take = '0;
    logic        flush = 1'b0;
    logic        fetch_ready;
    logic [1:0]  issue_valid;
    logic [63:0] issue_inst;
    logic [63:0] issue_pc;
    logic [3:0]  occupancy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    mips_issue_queue #(
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_pc    (fetch_pc),
        .fetch_cnt   (fetch_cnt),
        .fetch_ready (fetch_ready),
        .issue_valid (issue_valid),
        .issue_inst  (issue_inst),
        .issue_pc    (issue_pc),
        .issue_take  (issue_take),
        .flush       (flush),
        .occupancy   (occupancy)
    );

    task automatic drive(input bit fv, input logic [63:0] insts, input logic [31:0] pc,
                         input int cnt, input int take, input bit fl);
        fetch_valid = fv;
        fetch_inst  = insts;
        fetch_pc    = pc;
        fetch_cnt   = 2'(cnt);
        issue_take  = 2'(take);
        flush       = fl;
    endtask

    function automatic bit model_ready();
        return (DEPTH - q.size()) >= FETCH_W;
    endfunction

    function automatic bit model_bypass();
`ifdef ISSUEQ_BYPASS_EN
        return !rst && !flush && fetch_valid && model_ready() && (q.size() == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic ent_t fetch_slot(input int k);
        ent_t e;
        e.inst = fetch_inst[32*k +: 32];
        e.pc   = fetch_pc + 32'(4 * k);
        return e;
    endfunction

    // Expected issue buses: oldest queued entries, or the arriving bundle when bypassing.
    task automatic expected(output logic [1:0] v, output logic [63:0] i, output logic [63:0] p);
        ent_t e;
        v = '0; i = '0; p = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (k < q.size()) begin
                v[k] = 1'b1; i[32*k +: 32] = q[k].inst; p[32*k +: 32] = q[k].pc;
            end else if (model_bypass() && k < int'(fetch_cnt)) begin
                e = fetch_slot(k);
                v[k] = 1'b1; i[32*k +: 32] = e.inst; p[32*k +: 32] = e.pc;
            end
        end
    endtask

    // Advance one clock and apply the queue rules to the model.
    task automatic tick();
        int n, t, d;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            n = (fetch_valid && model_ready()) ? int'(fetch_cnt) : 0;
            t = int'(issue_take);
            if (model_bypass()) begin
                d = (t < n) ? t : n;
                for (int k = d; k < n; k++) q.push_back(fetch_slot(k));
            end else begin
                d = (t < q.size()) ? t : q.size();
                repeat (d) void'(q.pop_front());
                for (int k = 0; k < n; k++) q.push_back(fetch_slot(k));
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, '0, '0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd0 || fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: occupancy=%0d fetch_ready=%b, expected 0 and 1", occupancy, fetch_ready);
        end
        checks++;
        if (issue_valid !== 2'b00 || issue_inst !== 64'h0 || issue_pc !== 64'h0) begin
            failures++;
            $display("FAIL reset_issue: valid=%b inst=%h pc=%h, expected all zero", issue_valid, issue_inst, issue_pc);
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] a, b, c, d;
        logic [1:0]  ev;
        logic [63:0] ei, ep;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        do_reset();
        drive(1, {b, a}, 32'h0, 2, 0, 0);
        @(negedge clk);
        expected(ev, ei, ep);
        checks++;
        if (issue_valid !== ev || issue_inst !== ei || issue_pc !== ep) begin
            failures++;
            $display("FAIL push_first_cycle: valid=%b inst=%h pc=%h, expected valid=%b inst=%h pc=%h",
                     issue_valid, issue_inst, issue_pc, ev, ei, ep);
        end
        tick();
        drive(1, {d, c}, 32'h8, 2, 0, 0);
        tick();
        drive(0, '0, '0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd4 || issue_valid !== 2'b11 || issue_inst !== {b, a} || issue_pc !== {32'h4, 32'h0}) begin
            failures++;
            $display("FAIL push_two_bundles: occ=%0d valid=%b inst=%h pc=%h, expected occ=4 valid=11 inst=%h pc=%h",
                     occupancy, issue_valid, issue_inst, issue_pc, {b, a}, {32'h4, 32'h0});
        end
        drive(0, '0, '0, 0, 1, 0);
        tick();
        drive(0, '0, '0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd3 || issue_inst !== {c, b} || issue_pc !== {32'h8, 32'h4}) begin
            failures++;
            $display("FAIL take_one: occ=%0d inst=%h pc=%h, expected occ=3 inst=%h pc=%h",
                     occupancy, issue_inst, issue_pc, {c, b}, {32'h8, 32'h4});
        end
    endtask

    task automatic test_full();
        logic [1:0]  ev;
        logic [63:0] ei, ep;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, {$urandom, $urandom}, 32'h100 + 32'(8 * i), 2, 0, 0);
            tick();
        end
        drive(1, {$urandom, $urandom}, 32'h200, 2, 2, 0);
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd8 || fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL full: occ=%0d fetch_ready=%b, expected 8 and 0", occupancy, fetch_ready);
        end
        tick();
        drive(0, '0, '0, 0, 0, 0);
        @(negedge clk);
        expected(ev, ei, ep);
        checks++;
        if (occupancy !== 4'd6 || fetch_ready !== 1'b1 || issue_pc !== {32'h10c, 32'h108} || issue_inst !== ei) begin
            failures++;
            $display("FAIL full_reject: occ=%0d ready=%b pc=%h inst=%h, expected occ=6 ready=1 pc=%h inst=%h",
                     occupancy, fetch_ready, issue_pc, issue_inst, {32'h10c, 32'h108}, ei);
        end
    endtask

    task automatic test_single();
        logic [31:0] x;
        x = $urandom;
        do_reset();
        drive(1, {32'hdead_beef, x}, 32'h104, 1, 0, 0);
        tick();
        drive(0, '0, '0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd1 || issue_valid !== 2'b01 || issue_pc !== {32'h0, 32'h104} || issue_inst !== {32'h0, x}) begin
            failures++;
            $display("FAIL single_slot: occ=%0d valid=%b inst=%h pc=%h, expected occ=1 valid=01 inst=%h pc=%h",
                     occupancy, issue_valid, issue_inst, issue_pc, {32'h0, x}, {32'h0, 32'h104});
        end
    endtask

    task automatic test_wrap();
        logic [1:0]  ev;
        logic [63:0] ei, ep;
        int t;
        logic [31:0] pc;
        do_reset();
        pc = 32'h400;
        for (int i = 0; i < 20; i++) begin
            t = (q.size() >= 2) ? 2 : q.size();
`ifdef ISSUEQ_BYPASS_EN
            if (q.size() == 0) t = 2;
`endif
            drive(1, {$urandom, $urandom}, pc, 2, t, 0);
            @(negedge clk);
            expected(ev, ei, ep);
            checks++;
            if (issue_valid !== ev || issue_inst !== ei || issue_pc !== ep || occupancy !== 4'(q.size())) begin
                failures++;
                $display("FAIL wrap_stream[%0d]: valid=%b inst=%h pc=%h occ=%0d, expected valid=%b inst=%h pc=%h occ=%0d",
                         i, issue_valid, issue_inst, issue_pc, occupancy, ev, ei, ep, q.size());
            end
            tick();
            pc += 32'h8;
        end
        for (int i = 0; i < 16 && q.size() > 1; i++) begin
            drive(0, '0, '0, 0, 1, 0);
            tick();
        end
        if (q.size() == 0) begin
            drive(1, {32'h0, 32'(ev)}, 32'h800, 1, 0, 0);
            tick();
        end
        drive(0, '0, '0, 0, 2, 0);
        tick();
        drive(0, '0, '0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd0 || issue_valid !== 2'b00) begin
            failures++;
            $display("FAIL take_clamp: occ=%0d valid=%b, expected 0 and 00", occupancy, issue_valid);
        end
    endtask

    task automatic test_random();
        logic [1:0]  ev;
        logic [63:0] ei, ep;
        int avail, cnt;
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cnt = $urandom_range(1, 2);
            drive(($urandom % 4) != 0, {$urandom, $urandom}, $urandom, cnt, 0, ($urandom % 25) == 0);
            avail = model_bypass() ? cnt : q.size();
            issue_take = 2'($urandom_range(0, (avail < 2) ? avail : 2));
            @(negedge clk);
            expected(ev, ei, ep);
            checks++;
            if (issue_valid !== ev || issue_inst !== ei || issue_pc !== ep ||
                occupancy !== 4'(q.size()) || fetch_ready !== model_ready()) begin
                failures++;
                if (errs++ < 5)
                    $display("FAIL random[%0d]: valid=%b inst=%h pc=%h occ=%0d ready=%b, expected valid=%b inst=%h pc=%h occ=%0d ready=%b",
                             i, issue_valid, issue_inst, issue_pc, occupancy, fetch_ready,
                             ev, ei, ep, q.size(), model_ready());
            end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, {$urandom, $urandom}, 32'h0, 2, 0, 0);
        tick();
        drive(1, {$urandom, $urandom}, 32'h8, 2, 0, 0);
        tick();
        drive(1, {$urandom, $urandom}, 32'h10, 1, 0, 0);
        tick();
        drive(1, {$urandom, $urandom}, 32'h20, 2, 2, 1);
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd5) begin
            failures++;
            $display("FAIL flush_setup: occ=%0d, expected 5", occupancy);
        end
        tick();
        drive(0, '0, '0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd0 || issue_valid !== 2'b00 || fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush: occ=%0d valid=%b ready=%b, expected 0 00 1", occupancy, issue_valid, fetch_ready);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] e, f;
        e = $urandom; f = $urandom;
        do_reset();
        drive(1, {f, e}, 32'h300, 2, 2, 0);
        @(negedge clk);
        checks++;
`ifdef ISSUEQ_BYPASS_EN
        if (issue_valid !== 2'b11 || issue_inst !== {f, e} || issue_pc !== {32'h304, 32'h300}) begin
            failures++;
            $display("FAIL bypass_same_cycle: valid=%b inst=%h pc=%h, expected valid=11 inst=%h pc=%h",
                     issue_valid, issue_inst, issue_pc, {f, e}, {32'h304, 32'h300});
        end
`else
        if (issue_valid !== 2'b00 || issue_inst !== 64'h0) begin
            failures++;
            $display("FAIL no_bypass_same_cycle: valid=%b inst=%h, expected valid=00 inst=0", issue_valid, issue_inst);
        end
`endif
        tick();
        drive(0, '0, '0, 0, 0, 0);
        @(negedge clk);
        checks++;
`ifdef ISSUEQ_BYPASS_EN
        if (occupancy !== 4'd0 || issue_valid !== 2'b00) begin
            failures++;
            $display("FAIL bypass_next: occ=%0d valid=%b, expected 0 and 00", occupancy, issue_valid);
        end
`else
        if (occupancy !== 4'd2 || issue_inst !== {f, e} || issue_pc !== {32'h304, 32'h300}) begin
            failures++;
            $display("FAIL no_bypass_next: occ=%0d inst=%h pc=%h, expected occ=2 inst=%h pc=%h",
                     occupancy, issue_inst, issue_pc, {f, e}, {32'h304, 32'h300});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_full();
        test_single();
        test_wrap();
        test_flush();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
